// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner.
//   state_t  : scan phase within a digit slot (anodes off, then digit lit)
//   HEX_SEGS : active-low a..g segment codes, indexed by hex nibble
//   SEG_OFF  : all segments dark
//   AN_OFF   : all anodes off
package seg_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Entry n holds the pattern for hex digit n; bit 6 = segment a, bit 0 = g.
  localparam logic [15:0][6:0] HEX_SEGS = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/hex2seg.sv
// Combinational hex-to-seven-segment decoder.
//   hex  : 4-bit nibble to display
//   segs : active-low segments a..g on segs[6:0]
module hex2seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  assign segs = HEX_SEGS[hex];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment display scanner.
// Each digit owns a slot of DIV clock cycles; the first BLANK cycles of a
// slot keep every anode off so the previous digit cannot ghost into the
// next one. New values are double-buffered and only reach the display at
// the digit3 -> digit0 wrap, so a frame never shows a mix of two values.
//   clk, rst : clock and synchronous active-high reset
//   value    : four hex digits, digit0 = value[3:0]
//   load     : strobe capturing value into the pending register
//   dp_in    : per-digit decimal point request (active-high, live)
//   lzb_en   : leading-zero blanking enable
//   segs     : segments a..g, active-low, registered
//   an       : digit anodes, active-low, registered
//   dp       : decimal point, active-low, registered
//   frame    : one-cycle pulse on the last cycle of the digit3 slot
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  output logic [6:0]  segs,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  state_t        state_reg;
  logic [15:0]   pending_reg;
  logic [15:0]   display_reg;
  logic [6:0]    segs_reg;
  logic [3:0]    an_reg;
  logic          dp_reg;
  logic          frame_reg;

  logic [CW-1:0] cnt_next;
  logic [1:0]    idx_next;
  state_t        state_next;
  logic          slot_end;
  logic          wrap;
  logic [3:0]    nibble;
  logic [6:0]    dec_segs;
  logic [3:0]    an_show;
  logic [3:0]    lz_blank;

  assign slot_end = (cnt_reg == CNT_MAX);
  assign wrap     = slot_end && (idx_reg == 2'd3);
  assign cnt_next = slot_end ? '0 : cnt_reg + 1'b1;
  assign idx_next = slot_end ? idx_reg + 2'd1 : idx_reg;

  // The phase follows the counter value the next cycle will hold, so the
  // registered state always agrees with cnt_reg. With BLANK = 0 no count
  // is below the threshold and every cycle is S_SHOW.
  assign state_next = (BLANK != 0 && cnt_next < BLANK_C) ? S_BLANK : S_SHOW;

  assign nibble  = display_reg[{idx_reg, 2'b00} +: 4];
  assign an_show = ~(4'b0001 << idx_reg);

  // Digit n is a leading zero when it and every higher digit are zero.
  // Digit0 is never blanked so a zero value still shows one "0".
  assign lz_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign lz_blank[gi] = lzb_en && (display_reg[15:4*gi] == '0);
    end
  endgenerate

  hex2seg u_hex2seg (
    .hex  (nibble),
    .segs (dec_segs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      idx_reg     <= 2'd0;
      state_reg   <= S_BLANK;
      pending_reg <= 16'h0000;
      display_reg <= 16'h0000;
      segs_reg    <= SEG_OFF;
      an_reg      <= AN_OFF;
      dp_reg      <= 1'b1;
      frame_reg   <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      state_reg <= state_next;

      if (load) begin
        pending_reg <= value;
      end
      // A load landing on the wrap cycle goes straight to the display.
      if (wrap) begin
        display_reg <= load ? value : pending_reg;
      end

      case (state_reg)
        S_SHOW: begin
          an_reg   <= lz_blank[idx_reg] ? AN_OFF : an_show;
          segs_reg <= dec_segs;
          dp_reg   <= ~dp_in[idx_reg];
        end
        default: begin
          an_reg   <= AN_OFF;
          segs_reg <= SEG_OFF;
          dp_reg   <= 1'b1;
        end
      endcase

      frame_reg <= wrap;
    end
  end

  assign segs  = segs_reg;
  assign an    = an_reg;
  assign dp    = dp_reg;
  assign frame = frame_reg;

endmodule
